// File: rtl/timer_pkg.sv
// Purpose: shared register map, field bit positions and APB state type for the timer peripheral.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package timer_pkg;

  // Byte offsets of the mapped registers; decode only looks at PADDR[4:2].
  localparam logic [4:0] TCR_OFS  = 5'h00;
  localparam logic [4:0] TCNT_OFS = 5'h04;
  localparam logic [4:0] PSC_OFS  = 5'h08;
  localparam logic [4:0] ARR_OFS  = 5'h0C;
  localparam logic [4:0] TSR_OFS  = 5'h10;

  // Field positions inside TCR and TSR.
  localparam int EN_BIT      = 0;
  localparam int CLR_BIT     = 1;
  localparam int ONESHOT_BIT = 2;
  localparam int UIF_BIT     = 0;

  // APB responder state: idle/waiting for access, or signalling ready.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_READY = 1'b1
  } apb_state_e;

endpackage

// File: rtl/timer_core.sv
// Purpose: prescaler, up-counter and compare/reload with one-shot stop request.
// Latency: state updates on the edge after inputs; upd_pulse/oneshot_stop are combinational from current state.
// Backpressure: none; counts whenever en is high, clr always wins.
module timer_core #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             oneshot,
  input  logic [PSC_W-1:0] psc,
  input  logic [CNT_W-1:0] arr,
  output logic [CNT_W-1:0] tcnt,
  output logic             upd_pulse,
  output logic             oneshot_stop
);

  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             tick;

  // Next prescale/count value; clear beats any tick, disable freezes both counters.
  always_comb begin
    psc_cnt_d    = psc_cnt_q;
    tcnt_d       = tcnt_q;
    tick         = 1'b0;
    upd_pulse    = 1'b0;
    oneshot_stop = 1'b0;
    if (clr) begin
      psc_cnt_d = '0;
      tcnt_d    = '0;
    end else if (en) begin
      if (psc_cnt_q == psc) begin
        psc_cnt_d = '0;
        tick      = 1'b1;
      end else begin
        psc_cnt_d = psc_cnt_q + PSC_ONE;
      end
      if (tick) begin
        // >= so that shrinking ARR below the running count reloads on the next tick.
        if (tcnt_q >= arr) begin
          tcnt_d       = '0;
          upd_pulse    = 1'b1;
          oneshot_stop = oneshot;
        end else begin
          tcnt_d = tcnt_q + CNT_ONE;
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt_q <= '0;
      tcnt_q    <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign tcnt = tcnt_q;

endmodule

// File: rtl/apb_timer_periph.sv
// Purpose: APB responder wrapping timer_core with TCR/TCNT/PSC/ARR/TSR registers and a level irq.
// Latency: every transfer completes with exactly one wait state; PRDATA/PREADY are registered.
// Backpressure: PREADY is held low for the first access cycle, then pulses high for one cycle.
module apb_timer_periph
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  apb_state_e       state_q, state_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             en_q, en_d;
  logic             oneshot_q, oneshot_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] arr_q, arr_d;
  logic             uif_q, uif_d;

  logic [4:0]       reg_ofs;
  logic             access, wr, rd;
  logic             wr_tcr, wr_psc, wr_arr, wr_tsr, clr;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] tcnt;
  logic             upd_pulse, oneshot_stop;
  logic             unused_bits;

  assign reg_ofs = {PADDR[4:2], 2'b00};
  assign access  = PSEL & PENABLE & (state_q == ST_IDLE);
  assign wr      = access & PWRITE;
  assign rd      = access & ~PWRITE;
  assign wr_tcr  = wr & (reg_ofs == TCR_OFS);
  assign wr_psc  = wr & (reg_ofs == PSC_OFS);
  assign wr_arr  = wr & (reg_ofs == ARR_OFS);
  assign wr_tsr  = wr & (reg_ofs == TSR_OFS);
  assign clr     = wr_tcr & PWDATA[CLR_BIT];

  // Byte-lane bits and upper write-data bits are intentionally ignored.
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  timer_core #(
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) u_core (
    .clk          (PCLK),
    .rst          (PRESET),
    .en           (en_q),
    .clr          (clr),
    .oneshot      (oneshot_q),
    .psc          (psc_q),
    .arr          (arr_q),
    .tcnt         (tcnt),
    .upd_pulse    (upd_pulse),
    .oneshot_stop (oneshot_stop)
  );

  // APB next state: one wait state, then a single ready cycle before accepting the next access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (access) state_d = ST_READY;
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read mux; fields are zero-extended, CLR and unmapped offsets read as 0.
  always_comb begin
    rdata = '0;
    case (reg_ofs)
      TCR_OFS: begin
        rdata[EN_BIT]      = en_q;
        rdata[ONESHOT_BIT] = oneshot_q;
      end
      TCNT_OFS: rdata[CNT_W-1:0] = tcnt;
      PSC_OFS:  rdata[PSC_W-1:0] = psc_q;
      ARR_OFS:  rdata[CNT_W-1:0] = arr_q;
      TSR_OFS:  rdata[UIF_BIT]   = uif_q;
      default:  rdata = '0;
    endcase
  end

  // Register writes; hardware one-shot stop and UIF set win over same-cycle software writes.
  always_comb begin
    prdata_d  = rd ? rdata : prdata_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    psc_d     = psc_q;
    arr_d     = arr_q;
    uif_d     = uif_q;
    if (wr_tcr) begin
      en_d      = PWDATA[EN_BIT];
      oneshot_d = PWDATA[ONESHOT_BIT];
    end
    if (oneshot_stop) en_d = 1'b0;
    if (wr_psc) psc_d = PWDATA[PSC_W-1:0];
    if (wr_arr) arr_d = PWDATA[CNT_W-1:0];
    if (wr_tsr && PWDATA[UIF_BIT]) uif_d = 1'b0;
    if (upd_pulse) uif_d = 1'b1;
  end

  // State and register flops; reset abandons any in-flight transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      prdata_q  <= '0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      psc_q     <= '0;
      arr_q     <= '0;
      uif_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      psc_q     <= psc_d;
      arr_q     <= arr_d;
      uif_q     <= uif_d;
    end
  end

  assign PRDATA = prdata_q;
  assign PREADY = (state_q == ST_READY);
  assign irq    = uif_q;

endmodule

// File: tb/tb_apb_timer_periph.sv
// Purpose: directed self-checking bench for apb_timer_periph over its APB port.
// Latency: each APB call starts 1ns after an edge and returns 1ns after its commit edge (3 edges later).
// Backpressure: waits for PREADY with a small cycle budget; an expired budget counts as an error.
module tb_apb_timer_periph;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [4:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_timer_periph dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_xfer(input logic w, input logic [4:0] a, input logic [31:0] wd,
                          output logic [31:0] rdat);
    int n;
    tick(1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
    check("ready_in_setup", {31'd0, PREADY}, 32'd0);
    tick(1);
    PENABLE = 1'b1;
    check("ready_first_access", {31'd0, PREADY}, 32'd0);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!PREADY && n < 4);
    check("ready_seen", {31'd0, PREADY}, 32'd1);
    check("wait_cycles", n, 1);
    rdat = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    apb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    apb_xfer(1'b0, a, 32'd0, d);
    check(tag, d, exp);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    tick(3);
    PRESET = 1'b0;

    // Reset state.
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    for (int i = 0; i < 8; i++) rd(5'(i * 4), 32'd0, $sformatf("rst_rd_%0h", i * 4));

    // PSC=3, ARR=4, enable: commit edge E0; ticks at E4,E8,E12,E16; reload at E20.
    wr(5'h08, 32'd3);
    wr(5'h0C, 32'd4);
    wr(5'h00, 32'h1);
    rd(5'h04, 32'd0, "cnt_e3");
    rd(5'h04, 32'd1, "cnt_e6");
    rd(5'h04, 32'd2, "cnt_e9");
    rd(5'h04, 32'd2, "cnt_e12");
    check("irq_e12", {31'd0, irq}, 32'd0);
    tick(7);
    check("irq_e19", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_e20", {31'd0, irq}, 32'd1);
    rd(5'h10, 32'd1, "tsr_uif");
    rd(5'h04, 32'd1, "cnt_after_wrap");

    // W1C clears UIF (commit E29), then a W1C on the reload edge E40 loses to the set.
    wr(5'h10, 32'h1);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    tick(8);
    check("irq_e37", {31'd0, irq}, 32'd0);
    wr(5'h10, 32'h1);
    check("irq_set_beats_w1c", {31'd0, irq}, 32'd1);

    // Stop with CLR, clear UIF, confirm quiescent state.
    wr(5'h00, 32'h2);
    wr(5'h10, 32'h1);
    rd(5'h00, 32'd0, "tcr_stopped");
    rd(5'h04, 32'd0, "cnt_cleared");
    rd(5'h10, 32'd0, "tsr_cleared");

    // One-shot: PSC=0, ARR=2, commit C; count 1,2,0 at C+1..C+3 then EN drops.
    wr(5'h08, 32'd0);
    wr(5'h0C, 32'd2);
    wr(5'h00, 32'h5);
    check("os_irq_start", {31'd0, irq}, 32'd0);
    rd(5'h04, 32'd2, "os_cnt_c2");
    check("os_irq_reload", {31'd0, irq}, 32'd1);
    rd(5'h00, 32'h4, "os_en_cleared");
    rd(5'h04, 32'd0, "os_cnt_hold");
    tick(5);
    rd(5'h04, 32'd0, "os_cnt_hold2");
    rd(5'h10, 32'd1, "os_uif");

    // Shrinking ARR below a running count: PSC=9, ARR=10, CLR+EN at S; TCNT=7 from S+70.
    wr(5'h10, 32'h1);
    wr(5'h08, 32'd9);
    wr(5'h0C, 32'd10);
    wr(5'h00, 32'h3);
    check("arr_irq_start", {31'd0, irq}, 32'd0);
    tick(70);
    wr(5'h0C, 32'd3);
    rd(5'h04, 32'd7, "arr_cnt7");
    check("arr_irq_s76", {31'd0, irq}, 32'd0);
    tick(3);
    check("arr_irq_s79", {31'd0, irq}, 32'd0);
    tick(1);
    check("arr_irq_s80", {31'd0, irq}, 32'd1);
    rd(5'h04, 32'd0, "arr_cnt_reloaded");
    wr(5'h00, 32'h3);
    rd(5'h00, 32'h1, "tcr_clr_reads0");
    tick(10);
    rd(5'h04, 32'd1, "cnt_after_clr");

    // Reset asserted during the access phase of a PSC write.
    tick(1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h08; PWDATA = 32'd5;
    tick(1);
    PENABLE = 1'b1; PRESET = 1'b1;
    tick(1);
    check("rst_mid_pready", {31'd0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick(1);
    PRESET = 1'b0;
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) rd(5'(i * 4), 32'd0, $sformatf("rst2_rd_%0h", i * 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
